dmem_bus_responder: RTL and testbench
=====================================

// Module: dmem_bus_responder
// PURPOSE
//  Responder side of the single-cycle CPU data-memory port (MemWrite, Mem_WrAddr, Mem_WrData -> ReadData).
//  Decodes each access to a word RAM or to an MMIO page holding a byte TX FIFO and a free-running cycle counter.
//  Reads are combinational, so the CPU samples ReadData in the same cycle. Writes commit on the rising clk edge.
//  The TX FIFO drains through a valid/ready byte stream towards a UART or debug sink.
// PARAMETERS
//  RAM_WORDS   1024          RAM depth in 32-bit words; RAM_WORDS*4 <= MMIO_BASE
//  FIFO_DEPTH  8             TX FIFO entries; power of 2, >= 2
//  MMIO_BASE   32'h0000_8000 byte address of the MMIO page, 4 KiB aligned
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  MemWrite    in   1   write strobe for the current access
//  Mem_WrAddr  in   32  byte address; bits [1:0] ignored (word access only)
//  Mem_WrData  in   32  write data
//  ReadData    out  32  read data, combinational from Mem_WrAddr
//  tx_data     out  8   FIFO head byte
//  tx_valid    out  1   FIFO not empty
//  tx_ready    in   1   sink accepts; pop when tx_valid && tx_ready at the clk edge
//  irq         out  1   timer-compare pending (see CONFIGURATION)
// BEHAVIOUR
//  Map: RAM at [0, RAM_WORDS*4). The MMIO page uses word offsets from MMIO_BASE:
//   +0x0 TXDATA  W: push Mem_WrData[7:0]; R: 0
//   +0x4 STATUS  R: {16'b0, count[7:0], 4'b0, pend, ovf, full, empty}; W: writing 1 to bit2 clears ovf, 1 to bit3 clears pend
//   +0x8 CYCLE   R: counter; W: load counter
//   +0xC TIMECMP (macro only)
//  Any other address reads 32'h0; writes to it are ignored.
//  Reset (reset=0, async): FIFO empty, rd/wr pointers 0, ovf=0, pend=0, CYCLE=0, TIMECMP=32'hFFFF_FFFF.
//   tx_valid=0, tx_data=0, irq=0. RAM contents are not reset.
//  RAM: the write lands at the edge; a read at the same address in the same cycle returns old data.
//  FIFO: push when the TXDATA write is accepted; pop on the tx_valid&&tx_ready edge; count 0..FIFO_DEPTH.
//   - Push while full with no pop: byte dropped, ovf set (sticky); count unchanged.
//   - Push while full with a pop in the same cycle: push accepted, count stays FIFO_DEPTH.
//   - Push while empty: tx_valid rises the next cycle (1-cycle latency); no bypass.
//   - Pointers wrap modulo FIFO_DEPTH; tx_data is held stable while tx_valid && !tx_ready.
//   - tx_ready while empty: no effect.
//  CYCLE: +1 every clk, wraps 32'hFFFF_FFFF -> 0. A write loads Mem_WrData; there is no increment that cycle.
//  The STATUS clear-write and a same-cycle set event: set wins.
//  Reset asserted mid-stream: the FIFO is flushed immediately and tx_valid drops asynchronously.
// CONFIGURATION
//  Macro DMEM_TIMER_CMP_EN. When defined:
//   - TIMECMP is read/write.
//   - pend sets at the edge where the pre-increment CYCLE value equals TIMECMP.
//   - irq = pend (registered).
//  When undefined: +0xC is unmapped, pend reads 0, irq tied 0.
// TESTING
//  1. Write 0x1234_5678 to 0x10, read 0x10 and 0x12 -> both 0x1234_5678; read 0x9000 -> 0.
//  2. tx_ready=0, push 0x41..0x48 -> STATUS=0x0802 (count 8, full). Push 0x49 -> ovf=1, 0x49 absent.
//  3. Same case as 2, continued: raise tx_ready -> bytes 0x41..0x48 in order on 8 consecutive cycles, then empty=1.
//  4. Full FIFO, push 0x55 with tx_ready=1 -> 0x55 accepted, count stays 8, ovf=0.
//  5. Write CYCLE=0xFFFF_FFFE, then read 2 cycles later -> 0x0000_0000 (wrap).
//     With the macro: TIMECMP=0x20, CYCLE=0x1E -> irq rises 3 cycles after the load.
//  6. Assert reset with 5 queued bytes while tx_valid=1 -> tx_valid=0 immediately; STATUS=0x0001 after release.

Source files
------------

// File: rtl/dmem_bus_responder.sv
// Data-memory responder: word RAM plus MMIO page (TX byte FIFO, cycle counter, optional TIMECMP via DMEM_TIMER_CMP_EN).
// Latency: reads are combinational from Mem_WrAddr; writes commit at the clk edge; a pushed byte is visible on tx next cycle.
// Backpressure: tx_data is held while tx_valid && !tx_ready; a push into a full FIFO with no pop is dropped and sets ovf.
module dmem_bus_responder #(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [PW:0] DEPTH     = (PW + 1)'(FIFO_DEPTH);

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          ovf;
  logic          pend;
  logic [31:0]   cycle;

  // Address decode: RAM region, then word registers inside the 4 KiB MMIO page
  logic          ram_sel, mmio_page;
  logic [9:0]    word_off;
  logic          txdata_sel, status_sel, cycle_sel;
  logic [AW-1:0] ram_idx;
  logic          unused_addr_bits;

  assign ram_sel          = (Mem_WrAddr < RAM_BYTES);
  assign mmio_page        = (Mem_WrAddr[31:12] == MMIO_BASE[31:12]);
  assign word_off         = Mem_WrAddr[11:2];
  assign txdata_sel       = mmio_page && (word_off == 10'd0);
  assign status_sel       = mmio_page && (word_off == 10'd1);
  assign cycle_sel        = mmio_page && (word_off == 10'd2);
  assign ram_idx          = Mem_WrAddr[AW+1:2];
  assign unused_addr_bits = ^Mem_WrAddr[1:0];

  // FIFO handshake: a push into a full FIFO is accepted only if a pop frees a slot in the same cycle
  logic full, empty, pop, push_req, push_ok, ovf_set, status_wr;
  assign empty     = (count == '0);
  assign full      = (count == DEPTH);
  assign tx_valid  = !empty;
  assign tx_data   = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign pop       = tx_valid && tx_ready;
  assign push_req  = MemWrite && txdata_sel;
  assign push_ok   = push_req && (!full || pop);
  assign ovf_set   = push_req && full && !pop;
  assign status_wr = MemWrite && status_sel;

  logic [31:0] status_dat;
  assign status_dat = {16'b0, 8'(count), 4'b0, pend, ovf, full, empty};

`ifdef DMEM_TIMER_CMP_EN
  logic        tcmp_sel;
  logic [31:0] timecmp;
  assign tcmp_sel = mmio_page && (word_off == 10'd3);

  // Compare register and sticky pending flag; a same-cycle match beats the clear-write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timecmp <= 32'hFFFF_FFFF;
      pend    <= 1'b0;
    end else begin
      if (MemWrite && tcmp_sel) timecmp <= Mem_WrData;
      if (cycle == timecmp)                 pend <= 1'b1;
      else if (status_wr && Mem_WrData[3])  pend <= 1'b0;
    end
  end
  assign irq = pend;
`else
  assign pend = 1'b0;
  assign irq  = 1'b0;
`endif

  // Combinational read mux; the CPU samples this in the same cycle
  always_comb begin
    ReadData = 32'h0;
    if (ram_sel)         ReadData = ram[ram_idx];
    else if (status_sel) ReadData = status_dat;
    else if (cycle_sel)  ReadData = cycle;
`ifdef DMEM_TIMER_CMP_EN
    else if (tcmp_sel)   ReadData = timecmp;
`endif
  end

  // RAM storage is not reset; a same-cycle read sees the old word
  always_ff @(posedge clk) begin
    if (MemWrite && ram_sel) ram[ram_idx] <= Mem_WrData;
  end

  // FIFO storage; only occupied slots are ever visible on tx_data
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= Mem_WrData[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow; reset flushes the FIFO asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)                          ovf <= 1'b1;
      else if (status_wr && Mem_WrData[2])  ovf <= 1'b0;
    end
  end

  // Free-running cycle counter; a load replaces the increment for that cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      cycle <= 32'h0;
    else if (MemWrite && cycle_sel)  cycle <= Mem_WrData;
    else                             cycle <= cycle + 32'h1;
  end

endmodule

// File: tb/tb_dmem_bus_responder.sv
module tb_dmem_bus_responder;

  localparam logic [31:0] A_TX     = 32'h0000_8000;
  localparam logic [31:0] A_STATUS = 32'h0000_8004;
  localparam logic [31:0] A_CYCLE  = 32'h0000_8008;
  localparam logic [31:0] A_TCMP   = 32'h0000_800C;

  logic        clk, reset, MemWrite, tx_ready;
  logic [31:0] Mem_WrAddr, Mem_WrData, ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid, irq;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt = 0;
  int pop_cnt   = 0;
  logic [7:0] exp_q[$];

  dmem_bus_responder dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Mem_WrAddr(Mem_WrAddr),
    .Mem_WrData(Mem_WrData), .ReadData(ReadData), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: a handshake seen mid-cycle pops at the next rising edge
  logic [7:0] mon_exp;
  always @(negedge clk) begin
    #2;
    if (reset && tx_valid && tx_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_pop: got byte %h while expected queue empty", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        model_cnt--;
        pop_cnt++;
        if (tx_data !== mon_exp) begin
          n_fail++;
          $display("FAIL tx_pop: got %h expected %h", tx_data, mon_exp);
        end
      end
    end
  end

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    MemWrite   = we;
    Mem_WrAddr = a;
    Mem_WrData = d;
    tx_ready   = rdy;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    drive(1'b0, a, 32'h0, tx_ready);
    #1 d = ReadData;
  endtask

  task automatic push(input logic [7:0] b, input logic rdy);
    drive(1'b1, A_TX, {24'h0, b}, rdy);
    #1;
    if (model_cnt < 8 || rdy) begin
      exp_q.push_back(b);
      model_cnt++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0; MemWrite = 1'b0; Mem_WrAddr = '0; Mem_WrData = '0; tx_ready = 1'b0;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b data=%h irq=%b expected 0/00/0", tx_valid, tx_data, irq);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    rd(A_STATUS, d);
    n_checks++;
    if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_status: got %h expected 00000001", d); end
  endtask

  task automatic test_ram();
    logic [31:0] d;
    drive(1'b1, 32'h10, 32'h1234_5678, 1'b0);
    rd(32'h10, d);
    n_checks++;
    if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_rd10: got %h expected 12345678", d); end
    rd(32'h12, d);
    n_checks++;
    if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_rd12: got %h expected 12345678", d); end
    rd(32'h9000, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_rd: got %h expected 00000000", d); end
    drive(1'b1, 32'h20, 32'hAAAA_AAAA, 1'b0);
    drive(1'b1, 32'h20, 32'hBBBB_BBBB, 1'b0);
    #1;
    n_checks++;
    if (ReadData !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL ram_old_data: got %h expected aaaaaaaa", ReadData); end
    rd(32'h20, d);
    n_checks++;
    if (d !== 32'hBBBB_BBBB) begin n_fail++; $display("FAIL ram_new_data: got %h expected bbbbbbbb", d); end
    drive(1'b1, 32'h0, 32'h0000_0011, 1'b0);
    drive(1'b1, 32'h1000, 32'h0000_0022, 1'b0);
    rd(32'h0, d);
    n_checks++;
    if (d !== 32'h0000_0011) begin n_fail++; $display("FAIL ram_no_alias: got %h expected 00000011", d); end
    rd(32'h1000, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ram_end_rd: got %h expected 00000000", d); end
    rd(A_TX, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL txdata_rd: got %h expected 00000000", d); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) push(8'h41 + 8'(i), 1'b0);
    rd(A_STATUS, d);
    n_checks++;
    if (d !== 32'h0000_0802) begin n_fail++; $display("FAIL fifo_full_status: got %h expected 00000802", d); end
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      n_fail++; $display("FAIL fifo_head: got valid=%b data=%h expected 1/41", tx_valid, tx_data);
    end
    push(8'h49, 1'b0);
    rd(A_STATUS, d);
    n_checks++;
    if (d !== 32'h0000_0806) begin n_fail++; $display("FAIL fifo_ovf_status: got %h expected 00000806", d); end
  endtask

  task automatic test_drain();
    logic [31:0] d;
    pop_cnt = 0;
    for (int i = 0; i < 8; i++) drive(1'b0, 32'h0, 32'h0, 1'b1);
    #3;
    n_checks++;
    if (pop_cnt !== 8 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL drain_8_cycles: got %0d pops, %0d left expected 8 pops, 0 left", pop_cnt, exp_q.size());
    end
    drive(1'b0, A_STATUS, 32'h0, 1'b0);
    #1 d = ReadData;
    n_checks++;
    if (d !== 32'h0000_0005) begin n_fail++; $display("FAIL drain_status: got %h expected 00000005", d); end
    drive(1'b1, A_STATUS, 32'h0000_0004, 1'b0);
    rd(A_STATUS, d);
    n_checks++;
    if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL ovf_clear: got %h expected 00000001", d); end
  endtask

  task automatic test_full_pop();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) push(8'h60 + 8'(i), 1'b0);
    push(8'h55, 1'b1);
    drive(1'b0, A_STATUS, 32'h0, 1'b0);
    #1 d = ReadData;
    n_checks++;
    if (d !== 32'h0000_0802) begin n_fail++; $display("FAIL full_pop_status: got %h expected 00000802", d); end
    pop_cnt = 0;
    for (int i = 0; i < 12; i++) drive(1'b0, 32'h0, 32'h0, 1'b1);
    #3;
    n_checks++;
    if (pop_cnt !== 8 || exp_q.size() != 0 || tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_drain: got %0d pops valid=%b expected 8 pops valid=0", pop_cnt, tx_valid);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_cycle();
    logic [31:0] d;
    drive(1'b1, A_CYCLE, 32'hFFFF_FFFE, 1'b0);
    rd(A_CYCLE, d);
    n_checks++;
    if (d !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL cycle_load: got %h expected fffffffe", d); end
    rd(A_CYCLE, d);
    n_checks++;
    if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cycle_inc: got %h expected ffffffff", d); end
    rd(A_CYCLE, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL cycle_wrap: got %h expected 00000000", d); end
`ifdef DMEM_TIMER_CMP_EN
    drive(1'b1, A_STATUS, 32'h0000_0008, 1'b0);
`else
    rd(A_TCMP, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL tcmp_unmapped: got %h expected 00000000", d); end
`endif
  endtask

`ifdef DMEM_TIMER_CMP_EN
  task automatic test_timer();
    logic [31:0] d;
    logic [3:0]  irq_seen;
    drive(1'b1, A_TCMP, 32'h20, 1'b0);
    drive(1'b1, A_CYCLE, 32'h1E, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      #1 irq_seen[i] = irq;
    end
    n_checks++;
    if (irq_seen !== 4'b1000) begin n_fail++; $display("FAIL irq_timing: got %b expected 1000", irq_seen); end
    rd(A_STATUS, d);
    n_checks++;
    if (d !== 32'h0000_0009) begin n_fail++; $display("FAIL pend_status: got %h expected 00000009", d); end
    rd(A_TCMP, d);
    n_checks++;
    if (d !== 32'h20) begin n_fail++; $display("FAIL tcmp_rd: got %h expected 00000020", d); end
    drive(1'b1, A_STATUS, 32'h0000_0008, 1'b0);
    rd(A_STATUS, d);
    n_checks++;
    if (d !== 32'h0000_0001 || irq !== 1'b0) begin
      n_fail++; $display("FAIL pend_clear: got %h irq=%b expected 00000001 irq=0", d, irq);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d;
    for (int i = 0; i < 5; i++) push(8'h70 + 8'(i), 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    n_checks++;
    if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b expected 1", tx_valid); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL async_flush: got valid=%b data=%h expected 0/00", tx_valid, tx_data);
    end
    exp_q.delete();
    model_cnt = 0;
    @(negedge clk) reset = 1'b1;
    rd(A_STATUS, d);
    n_checks++;
    if (d !== 32'h0000_0001 || irq !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_status: got %h irq=%b expected 00000001 irq=0", d, irq);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_fifo_full();
    test_drain();
    test_full_pop();
    test_cycle();
`ifdef DMEM_TIMER_CMP_EN
    test_timer();
`endif
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
